// File: rtl/tx_chan_arb.sv
// tx_chan_arb: two-channel, frame-atomic round-robin arbiter that merges the
// control (txc) and data (txd) AXI-Stream pairs of two DMA channels into one
// txc/txd pair for the offload input FSM. A frame is the full txc packet
// followed by the full txd packet of the same channel; the grant is held for
// the whole frame.
//
// Handshake semantics (all streams): a beat transfers on a rising edge where
// tvalid and tready are both 1. This block never makes a channel's tready
// depend on anything but state, grant and the downstream tready, and it only
// raises an m_*_tvalid by forwarding the granted channel's tvalid, so no beat
// is created, dropped or duplicated.
module tx_chan_arb #(
  parameter int C_FCNT_W = 16
) (
  input  logic                mm2s_clk,
  input  logic                mm2s_resetn,
  input  logic                arb_enable,

  input  logic [31:0]         s0_txc_tdata,
  input  logic [3:0]          s0_txc_tkeep,
  input  logic                s0_txc_tvalid,
  input  logic                s0_txc_tlast,
  output logic                s0_txc_tready,
  input  logic [63:0]         s0_txd_tdata,
  input  logic [7:0]          s0_txd_tkeep,
  input  logic                s0_txd_tvalid,
  input  logic                s0_txd_tlast,
  output logic                s0_txd_tready,

  input  logic [31:0]         s1_txc_tdata,
  input  logic [3:0]          s1_txc_tkeep,
  input  logic                s1_txc_tvalid,
  input  logic                s1_txc_tlast,
  output logic                s1_txc_tready,
  input  logic [63:0]         s1_txd_tdata,
  input  logic [7:0]          s1_txd_tkeep,
  input  logic                s1_txd_tvalid,
  input  logic                s1_txd_tlast,
  output logic                s1_txd_tready,

  output logic [31:0]         m_txc_tdata,
  output logic [3:0]          m_txc_tkeep,
  output logic                m_txc_tvalid,
  output logic                m_txc_tlast,
  input  logic                m_txc_tready,
  output logic [63:0]         m_txd_tdata,
  output logic [7:0]          m_txd_tkeep,
  output logic                m_txd_tvalid,
  output logic                m_txd_tlast,
  input  logic                m_txd_tready,

  output logic [C_FCNT_W-1:0] ch0_frames,
  output logic [C_FCNT_W-1:0] ch1_frames,
  output logic [3:0]          arb_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CTRL = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;
  logic   last_grant;
  logic   frame_done;
  logic   pick;
  logic   in_ctrl, in_data;
  logic   c_hs, d_hs;

  assign in_ctrl = (state == S_CTRL);
  assign in_data = (state == S_DATA);

  // Round robin: a lone requester wins; on a tie the channel that did not
  // finish the previous frame wins (last_grant resets to 1 so ch0 goes first).
  assign pick = (s0_txc_tvalid && s1_txc_tvalid) ? ~last_grant : s1_txc_tvalid;

  // Output muxes follow the grant; tvalid is gated so it only shows in the
  // phase that owns the stream.
  assign m_txc_tdata  = grant ? s1_txc_tdata  : s0_txc_tdata;
  assign m_txc_tkeep  = grant ? s1_txc_tkeep  : s0_txc_tkeep;
  assign m_txc_tlast  = grant ? s1_txc_tlast  : s0_txc_tlast;
  assign m_txc_tvalid = in_ctrl & (grant ? s1_txc_tvalid : s0_txc_tvalid);

  assign m_txd_tdata  = grant ? s1_txd_tdata  : s0_txd_tdata;
  assign m_txd_tkeep  = grant ? s1_txd_tkeep  : s0_txd_tkeep;
  assign m_txd_tlast  = grant ? s1_txd_tlast  : s0_txd_tlast;
  assign m_txd_tvalid = in_data & (grant ? s1_txd_tvalid : s0_txd_tvalid);

  // Only the granted channel, and only in its phase, sees downstream ready.
  assign s0_txc_tready = in_ctrl & ~grant & m_txc_tready;
  assign s1_txc_tready = in_ctrl &  grant & m_txc_tready;
  assign s0_txd_tready = in_data & ~grant & m_txd_tready;
  assign s1_txd_tready = in_data &  grant & m_txd_tready;

  assign c_hs = m_txc_tvalid & m_txc_tready;
  assign d_hs = m_txd_tvalid & m_txd_tready;

  assign arb_dbg = {grant, last_grant, state};

  // Next-state logic: grant is only ever loaded on the IDLE exit.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_enable && (s0_txc_tvalid || s1_txc_tvalid)) begin
          state_nxt = S_CTRL;
          grant_nxt = pick;
        end
      end
      S_CTRL: begin
        if (c_hs && m_txc_tlast) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (d_hs && m_txd_tlast) begin
          state_nxt  = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, grant and round-robin history registers.
  always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
    if (!mm2s_resetn) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (frame_done) last_grant <= grant;
    end
  end

  // Completed-frame counters; they wrap naturally at all-ones.
  always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
    if (!mm2s_resetn) begin
      ch0_frames <= '0;
      ch1_frames <= '0;
    end else if (frame_done) begin
      if (grant) ch1_frames <= ch1_frames + C_FCNT_W'(1);
      else       ch0_frames <= ch0_frames + C_FCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tx_chan_arb.sv
// tb_tx_chan_arb: directed bench for tx_chan_arb (C_FCNT_W=8 so the counter
// wrap is reachable). Channel drivers present beats and advance on handshake;
// a negedge monitor pops the expected queues on every downstream transfer.
module tb_tx_chan_arb;

  localparam int TMO = 200;

  // ---------------- clock / reset ----------------
  logic mm2s_clk = 1'b0;
  logic mm2s_resetn;
  logic arb_enable;
  always #10 mm2s_clk = ~mm2s_clk;

  // ---------------- DUT signals ----------------
  logic [31:0] txc_data [2];
  logic [3:0]  txc_keep [2];
  logic        txc_vld  [2];
  logic        txc_last [2];
  logic [63:0] txd_data [2];
  logic [7:0]  txd_keep [2];
  logic        txd_vld  [2];
  logic        txd_last [2];
  logic [1:0]  txc_rdy, txd_rdy;

  logic [31:0] m_txc_tdata;
  logic [3:0]  m_txc_tkeep;
  logic        m_txc_tvalid, m_txc_tlast, m_txc_tready;
  logic [63:0] m_txd_tdata;
  logic [7:0]  m_txd_tkeep;
  logic        m_txd_tvalid, m_txd_tlast, m_txd_tready;
  logic [7:0]  ch0_frames, ch1_frames;
  logic [3:0]  arb_dbg;

  tx_chan_arb #(.C_FCNT_W(8)) dut (
    .mm2s_clk     (mm2s_clk),
    .mm2s_resetn  (mm2s_resetn),
    .arb_enable   (arb_enable),
    .s0_txc_tdata (txc_data[0]),
    .s0_txc_tkeep (txc_keep[0]),
    .s0_txc_tvalid(txc_vld[0]),
    .s0_txc_tlast (txc_last[0]),
    .s0_txc_tready(txc_rdy[0]),
    .s0_txd_tdata (txd_data[0]),
    .s0_txd_tkeep (txd_keep[0]),
    .s0_txd_tvalid(txd_vld[0]),
    .s0_txd_tlast (txd_last[0]),
    .s0_txd_tready(txd_rdy[0]),
    .s1_txc_tdata (txc_data[1]),
    .s1_txc_tkeep (txc_keep[1]),
    .s1_txc_tvalid(txc_vld[1]),
    .s1_txc_tlast (txc_last[1]),
    .s1_txc_tready(txc_rdy[1]),
    .s1_txd_tdata (txd_data[1]),
    .s1_txd_tkeep (txd_keep[1]),
    .s1_txd_tvalid(txd_vld[1]),
    .s1_txd_tlast (txd_last[1]),
    .s1_txd_tready(txd_rdy[1]),
    .m_txc_tdata  (m_txc_tdata),
    .m_txc_tkeep  (m_txc_tkeep),
    .m_txc_tvalid (m_txc_tvalid),
    .m_txc_tlast  (m_txc_tlast),
    .m_txc_tready (m_txc_tready),
    .m_txd_tdata  (m_txd_tdata),
    .m_txd_tkeep  (m_txd_tkeep),
    .m_txd_tvalid (m_txd_tvalid),
    .m_txd_tlast  (m_txd_tlast),
    .m_txd_tready (m_txd_tready),
    .ch0_frames   (ch0_frames),
    .ch1_frames   (ch1_frames),
    .arb_dbg      (arb_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [36:0] exp_c_q[$];
  logic [72:0] exp_d_q[$];
  logic        grant_log[$];
  logic        ctrl_done [2];
  int          cyc = 0;
  int          last_tl_cyc = 0;
  logic        have_tl = 1'b0;
  logic        prev_c_vld = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat encodings carry channel, frame id and beat index so order is checked.
  function automatic logic [36:0] c_beat(input int ch, input int id, input int b, input int n);
    return {(b == n - 1), 4'(b + 1), 8'(8'hC0 + ch), 8'(id), 16'(b)};
  endfunction

  function automatic logic [72:0] d_beat(input int ch, input int id, input int b, input int n);
    return {(b == n - 1), 8'(b + 3), 8'(8'hD0 + ch), 8'(id), 16'(b), 32'(b * 32'h0101_0101)};
  endfunction

  task automatic expect_frame(input int ch, input int id, input int nc, input int nd);
    for (int b = 0; b < nc; b++) exp_c_q.push_back(c_beat(ch, id, b, nc));
    for (int b = 0; b < nd; b++) exp_d_q.push_back(d_beat(ch, id, b, nd));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_rdy(input int ch, input bit is_d);
    int n = 0;
    forever begin
      @(negedge mm2s_clk);
      if ((is_d ? txd_rdy[ch] : txc_rdy[ch]) == 1'b1) break;
      n++;
      if (n >= TMO) break;
    end
    check(is_d ? "txd_wait_bound" : "txc_wait_bound", (n < TMO), 1'b1);
    @(posedge mm2s_clk);
    #1;
  endtask

  task automatic ch_send(input int ch, input int id, input int nc, input int nd);
    fork
      begin
        for (int b = 0; b < nc; b++) begin
          {txc_last[ch], txc_keep[ch], txc_data[ch]} = c_beat(ch, id, b, nc);
          txc_vld[ch] = 1'b1;
          wait_rdy(ch, 1'b0);
        end
        txc_vld[ch]   = 1'b0;
        ctrl_done[ch] = 1'b1;
      end
      begin
        for (int b = 0; b < nd; b++) begin
          {txd_last[ch], txd_keep[ch], txd_data[ch]} = d_beat(ch, id, b, nd);
          txd_vld[ch] = 1'b1;
          wait_rdy(ch, 1'b1);
        end
        txd_vld[ch] = 1'b0;
      end
    join
  endtask

  // ---------------- monitor ----------------
  // Pops expected beats on each downstream transfer and checks invariants.
  always @(negedge mm2s_clk) begin
    logic [36:0] ec;
    logic [72:0] ed;
    cyc++;
    if (mm2s_resetn) begin
      if (m_txc_tvalid && m_txc_tready) begin
        check("txc_q_nonempty", (exp_c_q.size() != 0), 1'b1);
        if (exp_c_q.size() != 0) begin
          ec = exp_c_q.pop_front();
          check("txc_beat", {m_txc_tlast, m_txc_tkeep, m_txc_tdata}, ec);
        end
        if (m_txc_tlast) grant_log.push_back(arb_dbg[3]);
      end
      if (m_txd_tvalid && m_txd_tready) begin
        check("txd_q_nonempty", (exp_d_q.size() != 0), 1'b1);
        if (exp_d_q.size() != 0) begin
          ed = exp_d_q.pop_front();
          check("txd_beat", {m_txd_tlast, m_txd_tkeep, m_txd_tdata}, ed);
        end
        if (m_txd_tlast) begin
          last_tl_cyc = cyc;
          have_tl     = 1'b1;
        end
      end
      if (m_txc_tvalid && !prev_c_vld && have_tl)
        check("b2b_idle_gap", ((cyc - last_tl_cyc) >= 2), 1'b1);
      check("rdy_one_channel", (txc_rdy != 2'b11) && (txd_rdy != 2'b11), 1'b1);
      check("rdy_one_phase", !((|txc_rdy) && (|txd_rdy)), 1'b1);
    end
    prev_c_vld = m_txc_tvalid;
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    mm2s_resetn  = 1'b0;
    arb_enable   = 1'b1;
    m_txc_tready = 1'b1;
    m_txd_tready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      txc_data[c] = '0; txc_keep[c] = '0; txc_vld[c] = 1'b0; txc_last[c] = 1'b0;
      txd_data[c] = '0; txd_keep[c] = '0; txd_vld[c] = 1'b0; txd_last[c] = 1'b0;
      ctrl_done[c] = 1'b0;
    end

    // Reset values
    #25;
    check("rst_dbg", arb_dbg, 4'b0100);
    check("rst_ch0_frames", ch0_frames, 8'd0);
    check("rst_ch1_frames", ch1_frames, 8'd0);
    check("rst_readies", {txc_rdy, txd_rdy}, 4'b0000);
    check("rst_m_valid", {m_txc_tvalid, m_txd_tvalid}, 2'b00);
    @(negedge mm2s_clk) mm2s_resetn = 1'b1;
    @(posedge mm2s_clk); #1;

    // Tie after reset: expected grant order ch0, ch1, ch0
    grant_log.delete();
    expect_frame(0, 10, 4, 3);
    expect_frame(1, 11, 2, 2);
    expect_frame(0, 12, 1, 1);
    fork
      begin ch_send(0, 10, 4, 3); ch_send(0, 12, 1, 1); end
      ch_send(1, 11, 2, 2);
    join
    repeat (2) @(posedge mm2s_clk); #1;
    check("tie_c_drained", exp_c_q.size(), 0);
    check("tie_d_drained", exp_d_q.size(), 0);
    check("tie_grant_cnt", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("tie_grant0", grant_log[0], 1'b0);
      check("tie_grant1", grant_log[1], 1'b1);
      check("tie_grant2", grant_log[2], 1'b0);
    end
    check("tie_ch0_frames", ch0_frames, 8'd2);
    check("tie_ch1_frames", ch1_frames, 8'd1);
    check("tie_dbg", arb_dbg, 4'b0000);

    // Single channel: ch0 4-beat txc, 3-beat txd; ch1 readies stay 0
    expect_frame(0, 1, 4, 3);
    fork
      ch_send(0, 1, 4, 3);
      for (int i = 0; i < 15; i++) begin
        @(negedge mm2s_clk);
        check("single_ch1_rdy", {txc_rdy[1], txd_rdy[1]}, 2'b00);
      end
    join
    repeat (2) @(posedge mm2s_clk); #1;
    check("single_d_drained", exp_d_q.size(), 0);
    check("single_ch0_frames", ch0_frames, 8'd3);

    // Backpressure on m_txd_tready: 1,0,0,1 mirrored on s0_txd_tready
    ctrl_done[0] = 1'b0;
    expect_frame(0, 3, 2, 4);
    fork
      ch_send(0, 3, 2, 4);
      begin
        for (int n = 0; !ctrl_done[0] && n < TMO; n++) @(posedge mm2s_clk);
        #2;
        for (int i = 0; i < 4; i++) begin
          m_txd_tready = pat[i];
          @(negedge mm2s_clk);
          check("bp_mirror", txd_rdy[0], pat[i]);
          @(posedge mm2s_clk); #2;
        end
        m_txd_tready = 1'b1;
      end
    join
    repeat (2) @(posedge mm2s_clk); #1;
    check("bp_d_drained", exp_d_q.size(), 0);
    check("bp_ch0_frames", ch0_frames, 8'd4);

    // arb_enable dropped during ch1 data phase; ch0 stays pending
    ctrl_done[1] = 1'b0;
    expect_frame(1, 20, 2, 4);
    {txc_last[0], txc_keep[0], txc_data[0]} = c_beat(0, 99, 0, 1);
    txc_vld[0] = 1'b1;
    fork
      ch_send(1, 20, 2, 4);
      begin
        for (int n = 0; !ctrl_done[1] && n < TMO; n++) @(posedge mm2s_clk);
        #2 arb_enable = 1'b0;
      end
    join
    repeat (5) @(negedge mm2s_clk);
    check("en_ch1_frames", ch1_frames, 8'd2);
    check("en_hold_idle", arb_dbg[1:0], 2'd0);
    check("en_no_grant", {m_txc_tvalid, txc_rdy[0]}, 2'b00);
    check("en_c_drained", exp_c_q.size(), 0);
    txc_vld[0] = 1'b0;
    arb_enable = 1'b1;
    @(posedge mm2s_clk); #1;

    // Arbitration latency, then reset during S_CTRL
    m_txc_tready = 1'b0;
    {txc_last[0], txc_keep[0], txc_data[0]} = c_beat(0, 30, 0, 2);
    txc_vld[0] = 1'b1;
    @(negedge mm2s_clk);
    check("lat_before_edge", m_txc_tvalid, 1'b0);
    @(negedge mm2s_clk);
    check("lat_after_edge", m_txc_tvalid, 1'b1);
    #2 m_txc_tready = 1'b1;
    #1 check("ctrl_rdy_pre_rst", txc_rdy[0], 1'b1);
    #1 mm2s_resetn = 1'b0;
    #1;
    check("midrst_m_valid", m_txc_tvalid, 1'b0);
    check("midrst_rdy", {txc_rdy, txd_rdy}, 4'b0000);
    check("midrst_dbg", arb_dbg, 4'b0100);
    check("midrst_frames", {ch0_frames, ch1_frames}, 16'd0);
    txc_vld[0] = 1'b0;
    repeat (2) @(posedge mm2s_clk);
    @(negedge mm2s_clk) mm2s_resetn = 1'b1;
    @(posedge mm2s_clk); #1;
    expect_frame(0, 31, 2, 2);
    ch_send(0, 31, 2, 2);
    repeat (2) @(posedge mm2s_clk); #1;
    check("postrst_ch0_frames", ch0_frames, 8'd1);
    check("postrst_ch1_frames", ch1_frames, 8'd0);
    check("postrst_d_drained", exp_d_q.size(), 0);

    // Counter wrap: 255 frames then one more
    @(negedge mm2s_clk) mm2s_resetn = 1'b0;
    @(negedge mm2s_clk) mm2s_resetn = 1'b1;
    @(posedge mm2s_clk); #1;
    for (int i = 0; i < 255; i++) begin
      expect_frame(0, i, 1, 1);
      ch_send(0, i, 1, 1);
    end
    repeat (2) @(posedge mm2s_clk); #1;
    check("wrap_preload", ch0_frames, 8'd255);
    expect_frame(0, 255, 1, 1);
    ch_send(0, 255, 1, 1);
    repeat (2) @(posedge mm2s_clk); #1;
    check("wrap_to_zero", ch0_frames, 8'd0);
    check("wrap_ch1_frames", ch1_frames, 8'd0);
    check("wrap_d_drained", exp_d_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
